// File: rtl/sram_mem_ctrl.sv
// Fixed-wait-state controller for an asynchronous 16-bit SRAM behind the sequencer's Mem_OE/Mem_WE strobes.
// Latency: read data valid WAIT_CYCLES+1 cycles after the request edge; write occupies WAIT_CYCLES+1 cycles.
// Backpressure: Busy is high outside IDLE; strobe edges seen while Busy are dropped, not queued.
// Optional build macro MMIO_EN: decodes MMIO_ADDR to the Switches/Hex_out I/O register instead of SRAM.
module sram_mem_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          ADDR_W      = 20,
  parameter logic [15:0] MMIO_ADDR   = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR,
  input  logic [15:0]       Switches,
  output logic [15:0]       Data_to_CPU,
  output logic              Data_valid,
  output logic              Busy,
  output logic [15:0]       Hex_out,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [15:0]       SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [15:0]       SRAM_DQ_in
);

`ifdef MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, READ, RD_DONE, WRITE, WR_HOLD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                oe_q, we_q;
  logic                mmio_q, mmio_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic [15:0]         dout_q, dout_d;
  logic [15:0]         hex_q, hex_d;
  logic                dvld_q, dvld_d;
  logic                busy_q, busy_d;
  logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                rd_req, wr_req, mmio_hit;

  assign rd_req   = Mem_OE & ~oe_q;
  assign wr_req   = Mem_WE & ~we_q;
  assign mmio_hit = MMIO_ON && (MAR == MMIO_ADDR);

  // Next-state, datapath capture and registered pin decode from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mmio_d   = mmio_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dout_d   = dout_q;
    hex_d    = hex_q;
    dvld_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read edge.
        if (wr_req) begin
          addr_d   = {{(ADDR_W-16){1'b0}}, MAR};
          dq_out_d = MDR;
          cnt_d    = 4'd0;
          mmio_d   = mmio_hit;
          state_d  = WRITE;
        end else if (rd_req) begin
          addr_d  = {{(ADDR_W-16){1'b0}}, MAR};
          cnt_d   = 4'd0;
          mmio_d  = mmio_hit;
          state_d = READ;
        end
      end
      READ: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          dout_d  = mmio_q ? Switches : SRAM_DQ_in;
          dvld_d  = 1'b1;
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      WRITE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) state_d = WR_HOLD;
      end
      WR_HOLD: begin
        if (mmio_q) hex_d = dq_out_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered, so decode them from where the FSM is heading.
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      READ: begin
        ce_n_d = mmio_d;
        oe_n_d = mmio_d;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
      WRITE: begin
        ce_n_d  = mmio_d;
        we_n_d  = mmio_d;
        ub_n_d  = 1'b0;
        lb_n_d  = 1'b0;
        dq_oe_d = ~mmio_d;
      end
      // Data stays driven one cycle past WE_N rising for hold time.
      WR_HOLD: dq_oe_d = ~mmio_d;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; synchronous reset aborts any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      mmio_q   <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= 16'h0000;
      dout_q   <= 16'h0000;
      hex_q    <= 16'h0000;
      dvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oe_q     <= Mem_OE;
      we_q     <= Mem_WE;
      mmio_q   <= mmio_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dout_q   <= dout_d;
      hex_q    <= hex_d;
      dvld_q   <= dvld_d;
      busy_q   <= busy_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  assign Data_to_CPU = dout_q;
  assign Data_valid  = dvld_q;
  assign Busy        = busy_q;
  assign Hex_out     = hex_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = ub_n_q;
  assign SRAM_LB_N   = lb_n_q;
  assign SRAM_DQ_out = dq_out_q;
  assign SRAM_DQ_oe  = dq_oe_q;

endmodule
